// File: rtl/ne16_stream_req_gen.sv
// ne16_stream_req_gen: turns NE16 control-FSM state entries into stream
// request descriptors, queues them, issues them to the streamer over a
// valid/ready handshake and tracks outstanding (issued, not completed) ones.
// Optional stall counter is enabled by defining NE16_STREAM_REQ_GEN_PERF_EN.

package ne16_stream_req_gen_pkg;
  typedef enum logic [3:0] {
    IDLE, LOAD, WEIGHTOFFS, MATRIXVEC, NORMQUANT,
    STREAMOUT, STREAMIN, UPDATEIDX, DONE
  } state_ne16_t;

  typedef struct packed {
    logic [31:0] weights;
    logic [31:0] infeat;
    logic [31:0] outfeat;
    logic [31:0] scale;
  } base_addr_ne16_t;
endpackage

module ne16_stream_req_gen
  import ne16_stream_req_gen_pkg::*;
#(
  parameter int QUEUE_DEPTH     = 4,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  state_ne16_t               state_i,
  input  logic                      state_change_i,
  input  base_addr_ne16_t           base_addr_i,
  input  logic [31:0]               cfg_ptr_infeat_i,
  input  logic [31:0]               cfg_ptr_weights_i,
  input  logic [31:0]               cfg_ptr_outfeat_i,
  input  logic [31:0]               cfg_ptr_scale_i,
  input  logic [4:0][LEN_WIDTH-1:0] cfg_len_i,
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output logic [31:0]               req_addr_o,
  output logic [LEN_WIDTH-1:0]      req_len_o,
  output logic [2:0]                req_kind_o,
  input  logic                      done_i,
  output logic [2:0]                outstanding_o,
  output logic                      idle_o,
  output logic                      err_overflow_o,
  output logic                      err_underflow_o,
  output logic [31:0]               perf_stall_o
);

  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DESC_W = 32 + LEN_WIDTH + 3;

  typedef enum logic {H_EMPTY, H_HOLD} head_state_t;

  logic                flush;
  logic                push_hit;
  logic [2:0]          push_kind;
  logic [31:0]         push_addr;
  logic [DESC_W-1:0]   push_desc;
  logic                push_req;
  logic                push_acc;
  logic                pop;
  logic                full;
  logic                out_full;
  logic                bypass;
  logic [DESC_W-1:0]   next_head;

  logic [DESC_W-1:0]   mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2:0]          outstanding_q;
  logic                err_ovf_q, err_udf_q;
  head_state_t         head_state_q;
  logic [DESC_W-1:0]   head_q;

  // Soft clear and reset behave identically.
  assign flush = rst_i | clear_i;

  // Decode stream-bearing state entries into kind and address.
  always_comb begin
    push_hit  = 1'b0;
    push_kind = 3'd0;
    push_addr = 32'd0;
    case (state_i)
      LOAD:       begin push_hit = 1'b1; push_kind = 3'd0; push_addr = cfg_ptr_infeat_i  + base_addr_i.infeat;  end
      WEIGHTOFFS: begin push_hit = 1'b1; push_kind = 3'd1; push_addr = cfg_ptr_weights_i + base_addr_i.weights; end
      STREAMIN:   begin push_hit = 1'b1; push_kind = 3'd2; push_addr = cfg_ptr_outfeat_i + base_addr_i.outfeat; end
      NORMQUANT:  begin push_hit = 1'b1; push_kind = 3'd3; push_addr = cfg_ptr_scale_i   + base_addr_i.scale;   end
      STREAMOUT:  begin push_hit = 1'b1; push_kind = 3'd4; push_addr = cfg_ptr_outfeat_i + base_addr_i.outfeat; end
      default:    ;
    endcase
  end

  assign push_desc = {push_addr, cfg_len_i[push_kind], push_kind};
  assign push_req  = state_change_i & push_hit & ~flush;

  assign full        = (count_q == CNT_W'(QUEUE_DEPTH));
  assign out_full    = (outstanding_q == 3'(MAX_OUTSTANDING));
  assign req_valid_o = (head_state_q == H_HOLD) & ~out_full;
  assign pop         = req_valid_o & req_ready_i;
  // A full queue still accepts a push when a pop frees a slot that cycle.
  assign push_acc    = push_req & (~full | pop);

  // Next-state pointers and occupancy.
  always_comb begin
    rd_ptr_d = pop      ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // The entry being written becomes the head when nothing older remains.
  assign bypass    = push_acc & ((count_q == '0) | ((count_q == CNT_W'(1)) & pop));
  assign next_head = bypass ? push_desc : mem_q[rd_ptr_d];

  // Descriptor storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_desc;
  end

  // Queue pointers and occupancy counter.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head FSM with registered descriptor fields.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      head_state_q <= H_EMPTY;
      head_q       <= '0;
    end else begin
      case (head_state_q)
        H_EMPTY: begin
          if (push_acc) begin
            head_state_q <= H_HOLD;
            head_q       <= push_desc;
          end
        end
        H_HOLD: begin
          if (pop) begin
            if (count_d == '0) begin
              head_state_q <= H_EMPTY;
              head_q       <= '0;
            end else begin
              head_q <= next_head;
            end
          end
        end
        default: begin
          head_state_q <= H_EMPTY;
          head_q       <= '0;
        end
      endcase
    end
  end

  // Outstanding-request counter and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      outstanding_q <= '0;
      err_ovf_q     <= 1'b0;
      err_udf_q     <= 1'b0;
    end else begin
      if (push_req & full & ~pop) err_ovf_q <= 1'b1;
      case ({pop, done_i})
        2'b10: outstanding_q <= outstanding_q + 3'd1;
        2'b01: begin
          if (outstanding_q == 3'd0) err_udf_q <= 1'b1;
          else                       outstanding_q <= outstanding_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign {req_addr_o, req_len_o, req_kind_o} = head_q;
  assign outstanding_o   = outstanding_q;
  assign idle_o          = (count_q == '0) & (outstanding_q == 3'd0);
  assign err_overflow_o  = err_ovf_q;
  assign err_underflow_o = err_udf_q;

`ifdef NE16_STREAM_REQ_GEN_PERF_EN
  logic        stall;
  logic [31:0] perf_q;
  assign stall = (count_q != '0) & (~req_ready_i | out_full);

  // Saturating count of cycles where a queued descriptor could not leave.
  always_ff @(posedge clk_i) begin
    if (flush)                                  perf_q <= '0;
    else if (stall && perf_q != 32'hFFFF_FFFF)  perf_q <= perf_q + 32'd1;
  end
  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_ne16_stream_req_gen.sv
// Directed bench for ne16_stream_req_gen with a descriptor scoreboard.
module tb_ne16_stream_req_gen;
  import ne16_stream_req_gen_pkg::*;

  logic              clk = 1'b0;
  logic              rst_i, clear_i, state_change_i, req_ready_i, done_i;
  state_ne16_t       state_i;
  base_addr_ne16_t   base_addr_i;
  logic [31:0]       ptr_in, ptr_w, ptr_of, ptr_sc;
  logic [4:0][15:0]  cfg_len;
  logic              req_valid_o, idle_o, err_overflow_o, err_underflow_o;
  logic [31:0]       req_addr_o, perf_stall_o;
  logic [15:0]       req_len_o;
  logic [2:0]        req_kind_o, outstanding_o;

  int total = 0;
  int bad   = 0;
  logic [50:0] sb [$];
  logic [31:0] p0;

  always #5 clk = ~clk;

  ne16_stream_req_gen dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .state_i(state_i),
    .state_change_i(state_change_i), .base_addr_i(base_addr_i),
    .cfg_ptr_infeat_i(ptr_in), .cfg_ptr_weights_i(ptr_w),
    .cfg_ptr_outfeat_i(ptr_of), .cfg_ptr_scale_i(ptr_sc), .cfg_len_i(cfg_len),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .req_len_o(req_len_o), .req_kind_o(req_kind_o), .done_i(done_i),
    .outstanding_o(outstanding_o), .idle_o(idle_o),
    .err_overflow_o(err_overflow_o), .err_underflow_o(err_underflow_o),
    .perf_stall_o(perf_stall_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end else
      $display("ok   %s = 0x%08h", name, act);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_desc(input logic [31:0] a, input logic [15:0] l, input logic [2:0] k);
    sb.push_back({a, l, k});
  endtask

  task automatic push(input state_ne16_t s);
    state_i = s; state_change_i = 1'b1;
    tick();
    state_change_i = 1'b0; state_i = IDLE;
  endtask

  task automatic pulse_done(input int n);
    done_i = 1'b1;
    repeat (n) tick();
    done_i = 1'b0;
  endtask

  // Monitor: every accepted descriptor is compared with the scoreboard head.
  always @(negedge clk) begin
    if (req_valid_o && req_ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL desc_unexpected: got addr=0x%08h len=%0d kind=%0d want none",
                 req_addr_o, req_len_o, req_kind_o);
      end else begin
        logic [50:0] e;
        e = sb.pop_front();
        if ({req_addr_o, req_len_o, req_kind_o} !== e) begin
          bad++;
          $display("FAIL desc: got addr=0x%08h len=%0d kind=%0d want addr=0x%08h len=%0d kind=%0d",
                   req_addr_o, req_len_o, req_kind_o, e[50:19], e[18:3], e[2:0]);
        end else
          $display("ok   desc addr=0x%08h len=%0d kind=%0d", req_addr_o, req_len_o, req_kind_o);
      end
    end
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; state_change_i = 1'b0; state_i = IDLE;
    req_ready_i = 1'b0; done_i = 1'b0;
    base_addr_i = '0; ptr_in = '0; ptr_w = '0; ptr_of = '0; ptr_sc = '0; cfg_len = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'd0, req_valid_o}, 32'd0);
    chk("rst_addr", req_addr_o, 32'd0);
    chk("rst_len_kind", {13'd0, req_len_o, req_kind_o}, 32'd0);
    chk("rst_outstanding", {29'd0, outstanding_o}, 32'd0);
    chk("rst_idle", {31'd0, idle_o}, 32'd1);
    chk("rst_errs", {30'd0, err_overflow_o, err_underflow_o}, 32'd0);
    chk("rst_perf", perf_stall_o, 32'd0);

    // Single LOAD request end to end.
    tick();
    ptr_in = 32'h1000; base_addr_i.infeat = 32'h40; cfg_len[0] = 16'd36;
    ptr_w  = 32'h2000; base_addr_i.weights = 32'h100; cfg_len[1] = 16'd64;
    ptr_of = 32'h3000; base_addr_i.outfeat = 32'h8;   cfg_len[2] = 16'd16;
    ptr_sc = 32'h4000; base_addr_i.scale   = 32'h4;   cfg_len[3] = 16'd8;
    cfg_len[4] = 16'd20;
    req_ready_i = 1'b1;
    expect_desc(32'h1040, 16'd36, 3'd0);
    push(LOAD);
    tick();
    @(negedge clk);
    chk("t1_outstanding", {29'd0, outstanding_o}, 32'd1);
    chk("t1_valid_after", {31'd0, req_valid_o}, 32'd0);
    tick();
    pulse_done(1);
    @(negedge clk);
    chk("t1_out_done", {29'd0, outstanding_o}, 32'd0);
    chk("t1_idle", {31'd0, idle_o}, 32'd1);

    // Five pushes into a depth-4 queue while stalled; the fifth is dropped.
    tick();
    req_ready_i = 1'b0;
    expect_desc(32'h1040, 16'd36, 3'd0);
    expect_desc(32'h2100, 16'd64, 3'd1);
    expect_desc(32'h3008, 16'd16, 3'd2);
    expect_desc(32'h4004, 16'd8,  3'd3);
    push(LOAD); push(WEIGHTOFFS); push(STREAMIN); push(NORMQUANT); push(STREAMOUT);
    @(negedge clk);
    chk("t2_overflow", {31'd0, err_overflow_o}, 32'd1);
    chk("t2_stall_valid", {31'd0, req_valid_o}, 32'd1);
    chk("t2_stall_addr", req_addr_o, 32'h1040);
    tick();
    req_ready_i = 1'b1;
    repeat (4) tick();
    req_ready_i = 1'b0;
    @(negedge clk);
    chk("t2_out4", {29'd0, outstanding_o}, 32'd4);
    chk("t2_not_idle", {31'd0, idle_o}, 32'd0);
    tick();
    pulse_done(4);
    @(negedge clk);
    chk("t2_out0", {29'd0, outstanding_o}, 32'd0);
    tick();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    @(negedge clk);
    chk("t2_clear_ovf", {31'd0, err_overflow_o}, 32'd0);

    // Full queue: simultaneous push and pop, then masking at MAX_OUTSTANDING.
    tick();
    expect_desc(32'h1040, 16'd36, 3'd0);
    expect_desc(32'h2100, 16'd64, 3'd1);
    expect_desc(32'h3008, 16'd16, 3'd2);
    expect_desc(32'h4004, 16'd8,  3'd3);
    push(LOAD); push(WEIGHTOFFS); push(STREAMIN); push(NORMQUANT);
    req_ready_i = 1'b1;
    expect_desc(32'h3008, 16'd20, 3'd4);
    push(STREAMOUT);
    req_ready_i = 1'b0;
    @(negedge clk);
    chk("t3_no_ovf", {31'd0, err_overflow_o}, 32'd0);
    tick();
    push(LOAD);
    @(negedge clk);
    chk("t3_still_full", {31'd0, err_overflow_o}, 32'd1);
    tick();
    req_ready_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("t3_masked", {31'd0, req_valid_o}, 32'd0);
    chk("t3_masked_notidle", {31'd0, idle_o}, 32'd0);
    chk("t3_out4", {29'd0, outstanding_o}, 32'd4);
    p0 = perf_stall_o;
    repeat (3) @(negedge clk);
`ifdef NE16_STREAM_REQ_GEN_PERF_EN
    chk("t3_perf", perf_stall_o, p0 + 32'd3);
`else
    chk("t3_perf", perf_stall_o, 32'd0);
`endif
    tick();
    pulse_done(1);
    tick();
    req_ready_i = 1'b0;
    @(negedge clk);
    chk("t3_drained_out", {29'd0, outstanding_o}, 32'd4);
    tick();
    pulse_done(4);
    @(negedge clk);
    chk("t3_idle", {31'd0, idle_o}, 32'd1);

    // Underflow, then clear with a coincident push.
    tick();
    pulse_done(1);
    @(negedge clk);
    chk("t4_underflow", {31'd0, err_underflow_o}, 32'd1);
    chk("t4_out0", {29'd0, outstanding_o}, 32'd0);
    tick();
    clear_i = 1'b1;
    push(LOAD);
    clear_i = 1'b0;
    @(negedge clk);
    chk("t4_clear_errs", {30'd0, err_overflow_o, err_underflow_o}, 32'd0);
    chk("t4_clear_idle", {31'd0, idle_o}, 32'd1);
    chk("t4_clear_valid", {31'd0, req_valid_o}, 32'd0);

    // Address wrap-around, then reset in the middle of a stall.
    tick();
    req_ready_i = 1'b1;
    ptr_w = 32'hFFFF_FFF0; base_addr_i.weights = 32'h20;
    expect_desc(32'h0000_0010, 16'd64, 3'd1);
    push(WEIGHTOFFS);
    tick();
    pulse_done(1);
    req_ready_i = 1'b0;
    push(NORMQUANT);
    @(negedge clk);
    chk("t5_stall_addr0", req_addr_o, 32'h4004);
    @(negedge clk);
    chk("t5_stall_addr1", req_addr_o, 32'h4004);
    chk("t5_stall_valid", {31'd0, req_valid_o}, 32'd1);
    tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", {31'd0, req_valid_o}, 32'd0);
    chk("t5_rst_idle", {31'd0, idle_o}, 32'd1);
    chk("t5_rst_addr", req_addr_o, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/ne16_stream_req_gen.md
Name: ne16_stream_req_gen

Overview:
- Sits directly downstream of the NE16 control FSM.
- Consumes its next-state, state-change strobe and base-address outputs, and turns each stream-bearing state entry into one stream request descriptor: address, length in words, and kind.
- Buffers descriptors in a small queue and hands them to the streamer over a valid/ready handshake.
- Tracks requests that have been issued but not yet completed, so the controller can tell when all traffic has drained.

Parameters:
QUEUE_DEPTH, 4, descriptor queue entries (power of two, >=2)
LEN_WIDTH, 16, width of length fields
MAX_OUTSTANDING, 4, maximum accepted-but-not-completed requests

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous soft clear, same effect as rst_i
state_i  in  state_ne16_t  FSM next state
state_change_i  in  1  FSM state-change strobe
base_addr_i  in  base_addr_ne16_t  per-tile offsets (weights, infeat, outfeat, scale)
cfg_ptr_infeat_i  in  32  infeat base pointer
cfg_ptr_weights_i  in  32  weights base pointer
cfg_ptr_outfeat_i  in  32  outfeat base pointer; used by both streamin and streamout
cfg_ptr_scale_i  in  32  scale base pointer
cfg_len_i  in  5xLEN_WIDTH  length per kind, indexed by kind
req_valid_o  out  1  descriptor valid
req_ready_i  in  1  streamer accepts descriptor
req_addr_o  out  32  descriptor address
req_len_o  out  LEN_WIDTH  descriptor length
req_kind_o  out  3  0=infeat, 1=weights, 2=streamin, 3=scale, 4=streamout
done_i  in  1  streamer completed one request (in order)
outstanding_o  out  3  accepted-not-done count
idle_o  out  1  queue empty and outstanding==0
err_overflow_o  out  1  sticky: push dropped
err_underflow_o  out  1  sticky: done_i with nothing outstanding
perf_stall_o  out  32  stall counter (optional feature)

Behaviour:
- Reset/clear: queue empty, counters zero, sticky errors cleared.
  - req_valid_o=0, req_addr_o=0, req_len_o=0, req_kind_o=0, outstanding_o=0, idle_o=1, perf_stall_o=0.
  - A push arriving in the same cycle as clear is discarded.
- Push decode: push happens only when state_change_i=1 and state_i is one of the states below; all other states push nothing. Address = pointer + offset, 32-bit wrap-around add, no saturation.
  - LOAD -> kind 0, addr = cfg_ptr_infeat_i + base_addr_i.infeat
  - WEIGHTOFFS -> kind 1, addr = cfg_ptr_weights_i + base_addr_i.weights
  - STREAMIN -> kind 2, addr = cfg_ptr_outfeat_i + base_addr_i.outfeat
  - NORMQUANT -> kind 3, addr = cfg_ptr_scale_i + base_addr_i.scale
  - STREAMOUT -> kind 4, addr = cfg_ptr_outfeat_i + base_addr_i.outfeat
  - len = cfg_len_i[kind], sampled at the push.
- Queue: synchronous FIFO, registered output, not fall-through.
  - A push into an empty queue raises req_valid_o on the next cycle (latency 1).
  - Head fields are held stable while req_valid_o=1 and req_ready_i=0.
- Pop rule: pop when req_valid_o & req_ready_i & (outstanding < MAX_OUTSTANDING).
  - req_valid_o is masked to 0 while outstanding == MAX_OUTSTANDING.
- Full queue:
  - Push with no pop in the same cycle: push dropped, err_overflow_o set.
  - Push and pop in the same cycle: both take effect, no error.
- Empty queue: req_valid_o=0; pointers wrap modulo QUEUE_DEPTH.
- Outstanding counter:
  - +1 on pop, -1 on done_i; simultaneous pop and done leaves it unchanged.
  - done_i while count==0 with no simultaneous pop: count stays 0, err_underflow_o set.
- idle_o is combinational: (queue empty) & (outstanding==0).
- Internal state machine, per queue head:
  - EMPTY -> HOLD on push.
  - HOLD -> HOLD while stalled or after a pop with the queue still non-empty.
  - HOLD -> EMPTY after a pop that leaves the queue empty.
  - Any state -> EMPTY on rst_i/clear_i.

Optional Feature:
- Macro NE16_STREAM_REQ_GEN_PERF_EN.
- When defined: perf_stall_o is a 32-bit saturating counter.
  - Increments in every cycle with queue non-empty and (~req_ready_i or outstanding==MAX_OUTSTANDING).
  - Cleared by rst_i/clear_i; holds at 0xFFFFFFFF once reached.
- When undefined: perf_stall_o tied to 0 and no counter flops are instantiated.

Test Plan:
- State change to LOAD with ptr_infeat=0x1000, offset 0x40, len[0]=36, ready=1 -> req_valid_o high next cycle with addr 0x1040, len 36, kind 0; outstanding_o=1 after accept; done_i -> outstanding_o=0, idle_o=1.
- Pushes for LOAD, WEIGHTOFFS, STREAMIN, NORMQUANT, STREAMOUT on consecutive cycles with ready=0, depth 4 -> first four queued in order (kinds 0, 1, 2, 3), fifth dropped, err_overflow_o=1; releasing ready drains kinds 0, 1, 2, 3 only.
- Queue full, push and pop in the same cycle -> no overflow, occupancy stays 4, order preserved.
- Four accepts with no done_i -> req_valid_o masked with queue non-empty; with PERF_EN, perf_stall_o increments by 1 per masked cycle; one done_i -> next descriptor issues.
- done_i with outstanding=0 -> err_underflow_o=1, outstanding_o stays 0; clear_i -> both sticky errors 0, idle_o=1.
- ptr=0xFFFFFFF0, offset 0x20 -> addr 0x00000010; rst_i asserted mid-stall -> req_valid_o=0 on the next cycle and the queue empty.
